// File: rtl/sample_i2s_output.sv
// sample_i2s_output
// Buffers mono 16-bit samples in a small FIFO and serializes them to an
// external DAC as Philips-format I2S. The sample goes out on both the left
// and the right channel. This block is the master for BCLK and LRCLK.
// Optional build macro: I2S_STATUS_COUNT_EN adds saturating 16-bit overrun
// and underrun event counters (o_OverrunCount, o_UnderrunCount).
module sample_i2s_output #(
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_SampleReady,
    input  logic [15:0]                   i_Sample,
    input  logic                          i_ClearStatus,
    output logic                          o_I2S_BCLK,
    output logic                          o_I2S_LRCLK,
    output logic                          o_I2S_SDATA,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
    output logic                          o_Overrun,
    output logic                          o_Underrun
`ifdef I2S_STATUS_COUNT_EN
    ,
    output logic [15:0]                   o_OverrunCount,
    output logic [15:0]                   o_UnderrunCount
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (BCLK_DIV <= 1) ? 1 : $clog2(BCLK_DIV);

    logic [DW-1:0]  r_Div;
    logic           r_Bclk;
    logic [4:0]     r_Slot;
    logic           r_Lrclk;
    logic           r_Sdata;
    logic [31:0]    r_Word;
    logic [15:0]    r_Mem [FIFO_DEPTH];
    logic [AW-1:0]  r_WrPtr;
    logic [AW-1:0]  r_RdPtr;
    logic [LW-1:0]  r_Level;
    logic           r_Overrun;
    logic           r_Underrun;

    logic           w_DivTc;
    logic           w_Fall;
    logic [4:0]     w_SlotNext;
    logic [4:0]     w_BitIdx;
    logic           w_Load;
    logic           w_Empty;
    logic           w_Full;
    logic           w_Pop;
    logic           w_Push;
    logic           w_Drop;
    logic           w_Under;

    assign w_DivTc    = (r_Div == DW'(BCLK_DIV - 1));
    assign w_Fall     = w_DivTc & r_Bclk;
    assign w_SlotNext = r_Slot + 5'd1;
    // One-BCLK I2S delay: entering slot s shows word bit (32 - s) mod 32,
    // so slot 0 still carries bit 0 of the outgoing right word.
    assign w_BitIdx   = 5'd0 - w_SlotNext;
    assign w_Load     = w_Fall & (w_SlotNext == 5'd0);

    assign w_Empty    = (r_Level == '0);
    assign w_Full     = (r_Level == LW'(FIFO_DEPTH));
    // Pop only sees entries present before this cycle: no push-to-pop bypass.
    assign w_Pop      = w_Load & ~w_Empty;
    assign w_Push     = i_SampleReady & (~w_Full | w_Pop);
    assign w_Drop     = i_SampleReady & w_Full & ~w_Pop;
    assign w_Under    = w_Load & w_Empty;

    // Bit-clock divider: toggle BCLK each time the divider wraps.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Div  <= '0;
            r_Bclk <= 1'b0;
        end else if (w_DivTc) begin
            r_Div  <= '0;
            r_Bclk <= ~r_Bclk;
        end else begin
            r_Div  <= r_Div + 1'b1;
        end
    end

    // Serial state: slot, word select, data bit and frame word on BCLK falls.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Slot  <= 5'd31;
            r_Lrclk <= 1'b0;
            r_Sdata <= 1'b0;
            r_Word  <= '0;
        end else if (w_Fall) begin
            r_Slot  <= w_SlotNext;
            r_Lrclk <= w_SlotNext[4];
            r_Sdata <= r_Word[w_BitIdx];
            if (w_Load)
                r_Word <= w_Pop ? {r_Mem[r_RdPtr], r_Mem[r_RdPtr]} : 32'd0;
        end
    end

    // FIFO storage; contents need no reset since the pointers are cleared.
    always_ff @(posedge i_Clock) begin
        if (w_Push)
            r_Mem[r_WrPtr] <= i_Sample;
    end

    // FIFO pointers and exact occupancy.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Level <= '0;
        end else begin
            if (w_Push)
                r_WrPtr <= r_WrPtr + 1'b1;
            if (w_Pop)
                r_RdPtr <= r_RdPtr + 1'b1;
            case ({w_Push, w_Pop})
                2'b10:   r_Level <= r_Level + 1'b1;
                2'b01:   r_Level <= r_Level - 1'b1;
                default: r_Level <= r_Level;
            endcase
        end
    end

    // Sticky status flags; a set event beats a coincident clear.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Overrun  <= 1'b0;
            r_Underrun <= 1'b0;
        end else begin
            r_Overrun  <= w_Drop  | (r_Overrun  & ~i_ClearStatus);
            r_Underrun <= w_Under | (r_Underrun & ~i_ClearStatus);
        end
    end

`ifdef I2S_STATUS_COUNT_EN
    logic [15:0] r_OverrunCount;
    logic [15:0] r_UnderrunCount;

    // Saturating event counters; an event coincident with clear counts as one.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_OverrunCount  <= '0;
            r_UnderrunCount <= '0;
        end else if (i_ClearStatus) begin
            r_OverrunCount  <= {15'd0, w_Drop};
            r_UnderrunCount <= {15'd0, w_Under};
        end else begin
            if (w_Drop && (r_OverrunCount != 16'hFFFF))
                r_OverrunCount <= r_OverrunCount + 16'd1;
            if (w_Under && (r_UnderrunCount != 16'hFFFF))
                r_UnderrunCount <= r_UnderrunCount + 16'd1;
        end
    end

    assign o_OverrunCount  = r_OverrunCount;
    assign o_UnderrunCount = r_UnderrunCount;
`endif

    assign o_I2S_BCLK  = r_Bclk;
    assign o_I2S_LRCLK = r_Lrclk;
    assign o_I2S_SDATA = r_Sdata;
    assign o_FifoLevel = r_Level;
    assign o_Overrun   = r_Overrun;
    assign o_Underrun  = r_Underrun;

endmodule
